// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display path.
// Imported by the scan controller and by the digit mux.
package disp_pkg;

    typedef logic [3:0]  digit_sel_t;
    typedef logic [15:0] bcd4_t;

    localparam digit_sel_t DIG_UNITS = 4'b0001;
    localparam digit_sel_t DIG_TENS  = 4'b0010;
    localparam digit_sel_t DIG_HUND  = 4'b0100;
    localparam digit_sel_t DIG_THOU  = 4'b1000;
    localparam digit_sel_t AN_OFF    = 4'b1111;

    // Leading-zero mask: a digit blanks only if every digit above it is zero too.
    function automatic digit_sel_t lz_blank_mask(input bcd4_t cdu, input logic blank_lz);
        digit_sel_t m;
        m[3] = blank_lz & (cdu[15:12] == 4'd0);
        m[2] = m[3]     & (cdu[11:8]  == 4'd0);
        m[1] = m[2]     & (cdu[7:4]   == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler for the display scan: counts 0..DIV-1 while enabled and strobes tick
// during the last count, so the consumer registers the advance on the wrap edge.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Display scan controller: rotates a one-hot digit select for the digit mux and drives
// active-low anodes with a post-switch ghosting guard and optional leading-zero blanking.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_HZ    = 27_000_000,
    parameter int DIGIT_HZ  = 1_000,
    parameter int GUARD_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       blank_lz,
    input  bcd4_t      cdu,
    output digit_sel_t digit_sel,
    output logic [3:0] an_n,
    output logic       scan_tick
);

    localparam int DIV = CLK_HZ / DIGIT_HZ;
    localparam int GW  = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC);

    logic       tick;
    digit_sel_t blank_mask;

    digit_sel_t    digit_sel_q, digit_sel_d;
    logic [3:0]    an_n_q, an_n_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          scan_tick_q;
    logic          en_q;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    assign blank_mask = lz_blank_mask(cdu, blank_lz);

    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        digit_sel_d = digit_sel_q;
        guard_d     = guard_q;
        an_n_d      = AN_OFF;
        if (!$onehot(digit_sel_q)) begin
            digit_sel_d = DIG_UNITS;
        end else if (en) begin
            if (tick) begin
                digit_sel_d = {digit_sel_q[2:0], digit_sel_q[3]};
                guard_d     = GUARD_LOAD;
            end else if (!en_q) begin
                guard_d = GUARD_LOAD;
            end else if (guard_q != '0) begin
                guard_d = guard_q - GW'(1);
            end
            // The anode lights in the cycle the guard reaches zero.
            if (guard_d == '0) begin
                an_n_d = ~(digit_sel_d & ~blank_mask);
            end
        end
    end

    // en_q resets high so a scan enabled straight out of reset is not treated as a restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel_q <= DIG_UNITS;
            an_n_q      <= AN_OFF;
            guard_q     <= GUARD_LOAD;
            scan_tick_q <= 1'b0;
            en_q        <= 1'b1;
        end else begin
            digit_sel_q <= digit_sel_d;
            an_n_q      <= an_n_d;
            guard_q     <= guard_d;
            scan_tick_q <= tick;
            en_q        <= en;
        end
    end

    assign digit_sel = digit_sel_q;
    assign an_n      = an_n_q;
    assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV=8, GUARD_CYC=2: rotation, guard, blanking,
// freeze/resume, illegal-select recovery and asynchronous reset.
module tb_display_scan_ctrl;
    import disp_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       blank_lz = 1'b0;
    bcd4_t      cdu = '0;
    digit_sel_t digit_sel;
    logic [3:0] an_n;
    logic       scan_tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .CLK_HZ    (16),
        .DIGIT_HZ  (2),
        .GUARD_CYC (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .blank_lz  (blank_lz),
        .cdu       (cdu),
        .digit_sel (digit_sel),
        .an_n      (an_n),
        .scan_tick (scan_tick)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Uninterrupted scanning: slot = cyc/8, tick on slot start, 2 dark cycles, then lit.
    task automatic run_scan(input int n, input logic [3:0] mask);
        logic [3:0] exp_sel;
        logic [3:0] exp_an;
        int pos;
        for (int i = 0; i < n; i++) begin
            step();
            pos     = cyc % 8;
            exp_sel = 4'b0001 << ((cyc / 8) % 4);
            exp_an  = (pos < 2) ? 4'b1111 : ~(exp_sel & ~mask);
            check($sformatf("sel@%0d", cyc), 16'(digit_sel), 16'(exp_sel));
            check($sformatf("tick@%0d", cyc), 16'(scan_tick), 16'(pos == 0));
            check($sformatf("an@%0d", cyc), 16'(an_n), 16'(exp_an));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_an;
        cdu      = 16'h1234;
        blank_lz = 1'b0;
        en       = 1'b1;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel", 16'(digit_sel), 16'h0001);
        check("rst_an", 16'(an_n), 16'h000f);
        check("rst_tick", 16'(scan_tick), 16'h0000);
        rst_n = 1'b1;
        cyc   = 0;

        // Full frames: no blanking, then leading-zero blanking on 0042 and 0000.
        run_scan(32, 4'b0000);
        cdu      = 16'h0042;
        blank_lz = 1'b1;
        run_scan(32, 4'b1100);
        cdu = 16'h0000;
        run_scan(32, 4'b1110);

        // Freeze mid-slot on the units digit (cycle 99, count 3).
        cdu      = 16'h1234;
        blank_lz = 1'b0;
        run_scan(3, 4'b0000);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("frz_sel%0d", i), 16'(digit_sel), 16'h0001);
            check($sformatf("frz_an%0d", i), 16'(an_n), 16'h000f);
            check($sformatf("frz_tick%0d", i), 16'(scan_tick), 16'h0000);
        end
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            exp_an = (k < 2 || k == 4) ? 4'b1111 : 4'b1110;
            check($sformatf("res_an%0d", k), 16'(an_n), 16'(exp_an));
            check($sformatf("res_tick%0d", k), 16'(scan_tick), 16'(k == 4));
            check($sformatf("res_sel%0d", k), 16'(digit_sel), (k == 4) ? 16'h0002 : 16'h0001);
        end
        run_scan(2, 4'b0000);

        // Illegal select deposited mid-slot on the tens digit.
        force dut.digit_sel_q = 4'b0110;
        #1;
        release dut.digit_sel_q;
        step();
        check("ill_sel", 16'(digit_sel), 16'h0001);
        check("ill_an", 16'(an_n), 16'h000f);
        check("ill_tick", 16'(scan_tick), 16'h0000);
        step();
        check("post_ill_sel", 16'(digit_sel), 16'h0001);
        check("post_ill_an", 16'(an_n), 16'h000e);

        // Rotation continues from units: tens at 112, hundreds at 120.
        while (cyc < 120) step();
        check("hund_tick", 16'(scan_tick), 16'h0001);
        check("hund_sel", 16'(digit_sel), 16'h0004);
        while (cyc < 123) step();
        check("pre_rst_sel", 16'(digit_sel), 16'h0004);
        check("pre_rst_an", 16'(an_n), 16'h000b);

        // Asynchronous reset mid-slot, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sel", 16'(digit_sel), 16'h0001);
        check("arst_an", 16'(an_n), 16'h000f);
        check("arst_tick", 16'(scan_tick), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("rel_tick%0d", k), 16'(scan_tick), 16'(k == 8));
            if (k == 1) check("rel_an1", 16'(an_n), 16'h000f);
            if (k == 2) check("rel_an2", 16'(an_n), 16'h000e);
            if (k == 8) check("rel_sel8", 16'(digit_sel), 16'h0002);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
